multi_blinker: RTL
==================

// Module: multi_blinker
// PURPOSE
//  N_CH-channel LED blinker with per-channel speed, set from four debounced push buttons.
//  btnl/btnr pick the channel to edit; btnu/btnd step its speed.
//  Each half-period is computed as BASE_TICKS * (2**IDX_W - speed); there is no lookup table.
//  A lock switch phase-aligns all channels onto channel 0's speed.
//  Sits between the board buttons/switches and the LED pins; one instance drives a bank of LEDs.
// PARAMETERS
//  N_CH            4           number of blink channels (>=2)
//  IDX_W           4           speed index width; speeds 0..2**IDX_W-1, max = fastest
//  BASE_TICKS      12_500_000  clk cycles per half-period at max speed
//  CNT_W           32          tick counter width; elaboration error if BASE_TICKS*2**IDX_W >= 2**CNT_W
//  DEBOUNCE_TICKS  1_000_000   consecutive stable cycles before a button/switch level is accepted (>=1)
//  RESET_SPEED     3           speed of every channel after reset (< 2**IDX_W)
// PORTS
//  clk        in   1                 system clock
//  rst        in   1                 synchronous, active-high reset
//  btnu       in   1                 async button: speed up (selected channel)
//  btnd       in   1                 async button: speed down
//  btnl       in   1                 async button: select previous channel
//  btnr       in   1                 async button: select next channel
//  lock       in   1                 async switch: 1 = lock-step mode
//  blink      out  N_CH              blink outputs, one per channel
//  sel_onehot out  N_CH              one-hot of selected channel
//  sel_speed  out  IDX_W             speed index of selected channel
// BEHAVIOUR
//  Clocking and reset
//  - Single clock domain; every flop updates on posedge clk.
//  - Reset: blink=0, sel=0 (sel_onehot=1), all speeds=RESET_SPEED, counters=0.
//  - Reset: each cur_ticks=target(RESET_SPEED), debounce state cleared, accepted levels=0.
//  - Reset mid-operation overrides everything in that cycle.
//  Input conditioning (each of the 5 inputs)
//  - 2-FF synchroniser, then debounce: a counter restarts on any change of the synced level.
//  - Accepted level updates when the synced level has been stable DEBOUNCE_TICKS cycles.
//  - Buttons: a rising edge of the accepted level gives a 1-cycle pulse.
//  - Latency from a clean input edge to the pulse is DEBOUNCE_TICKS+3 cycles.
//  - Holding a button never repeats.
//  Select
//  - btnr: sel+1, wrapping N_CH-1 -> 0. btnl: sel-1, wrapping 0 -> N_CH-1.
//  - btnr and btnl pulsing in the same cycle: btnr wins.
//  Speed
//  - btnu: speed[t]+1, saturating at 2**IDX_W-1. btnd: speed[t]-1, saturating at 0.
//  - btnu and btnd pulsing in the same cycle: btnu wins.
//  - t = sel as registered before this cycle's select update; in lock mode t = 0.
//  Target arithmetic
//  - target(s) = BASE_TICKS*(2**IDX_W - s), evaluated in CNT_W bits, unsigned.
//  Per-channel blinker
//  - If count == cur_ticks-1: count<=0, blink toggles, cur_ticks<=target(eff_speed). Otherwise count++.
//  - eff_speed = speed[ch], or speed[0] while lock=1.
//  - Speed changes take effect only at the next toggle, so a half-period is never truncated.
//  Lock mode
//  - Accepted lock 0->1: in that cycle every channel sets count=0, blink=0, cur_ticks=target(speed[0]).
//  - While locked, all channels toggle in the same cycle.
//  - Accepted lock 1->0: no realignment; each channel loads target(speed[ch]) at its next toggle.
//  Outputs
//  - sel_speed = speed[sel], combinational from registered state.
//  - blink and sel_onehot come directly from flops.
// TESTING  (N_CH=4, IDX_W=2, BASE_TICKS=4, DEBOUNCE_TICKS=3, RESET_SPEED=1)
//  1 Reset: release rst -> blink=0000, sel_onehot=0001, sel_speed=1.
//    All channels first toggle 12 cycles after reset release, then every 12 cycles.
//  2 Debounce: btnu glitch of 2 cycles -> no change.
//    btnu held 20 cycles -> sel_speed 1->2 exactly once, DEBOUNCE_TICKS+3 cycles after the edge.
//  3 Saturation: 3 btnu presses from speed 2 -> sel_speed 3.
//    4 btnd presses -> 0; a 5th btnd -> stays 0.
//  4 Wrap: btnl from sel 0 -> sel_onehot=1000; btnr -> 0001.
//    btnl+btnr pressed together -> sel_onehot=0010.
//  5 Glitch-free: raise ch0 speed 1->2 mid half-period -> current half-period stays 12 cycles, next is 8.
//  6 Lock: staggered channels, assert lock -> all blink=0 in one cycle, then all toggle together every target(speed[0]).
//    btnu with sel=2 changes speed[0]. rst pulse mid-run -> full reset values next cycle.

Source files
------------

// File: rtl/multi_blinker.sv
// Multi-channel LED blinker: debounced buttons select a channel and step its speed;
// each channel toggles every BASE_TICKS*(2**IDX_W - speed) cycles, optionally locked to channel 0.
module multi_blinker #(
  parameter int N_CH           = 4,
  parameter int IDX_W          = 4,
  parameter int BASE_TICKS     = 12_500_000,
  parameter int CNT_W          = 32,
  parameter int DEBOUNCE_TICKS = 1_000_000,
  parameter int RESET_SPEED    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btnu,
  input  logic              btnd,
  input  logic              btnl,
  input  logic              btnr,
  input  logic              lock,
  output logic [N_CH-1:0]   blink,
  output logic [N_CH-1:0]   sel_onehot,
  output logic [IDX_W-1:0]  sel_speed
);

  localparam int SEL_W = $clog2(N_CH);
  localparam int DB_W  = $clog2(DEBOUNCE_TICKS) + 1;
  localparam int NIN   = 5;
  localparam logic [IDX_W-1:0] SPD_MAX = '1;

  if (64'(BASE_TICKS) * (64'd1 << IDX_W) >= (64'd1 << CNT_W)) begin : g_chk_cnt
    $error("multi_blinker: BASE_TICKS*2**IDX_W does not fit in CNT_W bits");
  end
  if (N_CH < 2) begin : g_chk_nch
    $error("multi_blinker: N_CH must be at least 2");
  end
  if (DEBOUNCE_TICKS < 1) begin : g_chk_db
    $error("multi_blinker: DEBOUNCE_TICKS must be at least 1");
  end
  if (RESET_SPEED >= (2 ** IDX_W)) begin : g_chk_rs
    $error("multi_blinker: RESET_SPEED out of range");
  end

  function automatic logic [CNT_W-1:0] target(input logic [IDX_W-1:0] s);
    logic [CNT_W-1:0] steps;
    steps = CNT_W'(2 ** IDX_W) - CNT_W'(s);
    return CNT_W'(BASE_TICKS) * steps;
  endfunction

  function automatic logic [IDX_W-1:0] sat_inc(input logic [IDX_W-1:0] s);
    return (s == SPD_MAX) ? s : s + 1'b1;
  endfunction

  function automatic logic [IDX_W-1:0] sat_dec(input logic [IDX_W-1:0] s);
    return (s == '0) ? s : s - 1'b1;
  endfunction

  logic [NIN-1:0]  raw, sync_p0, sync_p1, acc, acc_d, rise;
  logic [DB_W-1:0] db_cnt [NIN];

  assign raw = {lock, btnr, btnl, btnd, btnu};

  // Stage p0/p1: two-flop synchroniser, then per-input debounce against the accepted level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      acc     <= '0;
      acc_d   <= '0;
      for (int i = 0; i < NIN; i++) db_cnt[i] <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      acc_d   <= acc;
      for (int i = 0; i < NIN; i++) begin
        if (sync_p1[i] != acc[i]) begin
          if (db_cnt[i] == DB_W'(DEBOUNCE_TICKS - 1)) begin
            acc[i]    <= sync_p1[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign rise = acc & ~acc_d;

  logic up, dn, left, right, lock_rise, locked;
  assign up        = rise[0];
  assign dn        = rise[1];
  assign left      = rise[2];
  assign right     = rise[3];
  assign lock_rise = rise[4];
  assign locked    = acc[4];

  logic [SEL_W-1:0] sel, sel_next, tgt;
  logic [IDX_W-1:0] speed [N_CH];

  always_comb begin
    sel_next = sel;
    if (right)
      sel_next = (sel == SEL_W'(N_CH - 1)) ? '0 : sel + 1'b1;
    else if (left)
      sel_next = (sel == '0) ? SEL_W'(N_CH - 1) : sel - 1'b1;
    tgt = locked ? '0 : sel;
  end

  // Edited channel is the one selected before this cycle's select move
  always_ff @(posedge clk) begin
    if (rst) begin
      sel        <= '0;
      sel_onehot <= N_CH'(1);
      for (int i = 0; i < N_CH; i++) speed[i] <= IDX_W'(RESET_SPEED);
    end else begin
      sel        <= sel_next;
      sel_onehot <= N_CH'(1) << sel_next;
      if (up)
        speed[tgt] <= sat_inc(speed[tgt]);
      else if (dn)
        speed[tgt] <= sat_dec(speed[tgt]);
    end
  end

  assign sel_speed = speed[sel];

  logic [IDX_W-1:0] eff_speed [N_CH];
  logic [CNT_W-1:0] count     [N_CH];
  logic [CNT_W-1:0] cur_ticks [N_CH];

  always_comb begin
    for (int i = 0; i < N_CH; i++) eff_speed[i] = locked ? speed[0] : speed[i];
  end

  // Half-period length is latched only at a toggle, so speed edits never cut one short
  always_ff @(posedge clk) begin
    if (rst) begin
      blink <= '0;
      for (int i = 0; i < N_CH; i++) begin
        count[i]     <= '0;
        cur_ticks[i] <= target(IDX_W'(RESET_SPEED));
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (lock_rise) begin
          count[i]     <= '0;
          blink[i]     <= 1'b0;
          cur_ticks[i] <= target(speed[0]);
        end else if (count[i] == cur_ticks[i] - 1'b1) begin
          count[i]     <= '0;
          blink[i]     <= ~blink[i];
          cur_ticks[i] <= target(eff_speed[i]);
        end else begin
          count[i]     <= count[i] + 1'b1;
        end
      end
    end
  end

endmodule
